fetch_queue: RTL and testbench

Instruction prefetch queue between the fetch stage (PC register plus instruction memory) and the decode stage. It buffers up to DEPTH fetched instruction/PC pairs, so a decode stall does not drop words that are already in flight from memory. It presents the oldest entry to decode in first-word-fall-through order. It discards all buffered work on a branch/jump flush. When empty or flushed, decode is fed a NOP bubble.

---
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch stage, the prefetch
// queue and the decode stage. The fetch/decode side drives through the
// master modport; the queue itself attaches through the slave modport.
interface fetch_queue_if #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Fetch side
  logic             ValidF;
  logic [SIZE-1:0]  PCF;
  logic [31:0]      InstrF;
  logic             ReadyF;

  // Decode side
  logic             StallD;
  logic             FlushD;
  logic             ValidD;
  logic [31:0]      InstrD;
  logic [SIZE-1:0]  PCD;
  logic [SIZE-1:0]  PCPlus4D;

  // Occupancy
  logic [CNT_W-1:0] Count;

  modport master (
    output ValidF, PCF, InstrF, StallD, FlushD,
    input  ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );

  modport slave (
    input  ValidF, PCF, InstrF, StallD, FlushD,
    output ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between fetch and decode.
// Circular buffer of DEPTH {PC, Instr} entries presented to decode in
// first-word-fall-through order. A flush discards everything, including a
// word arriving in the same cycle; an empty queue feeds decode a NOP bubble.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a fetched word reach
// decode combinationally in the same cycle while the queue is empty.
module fetch_queue #(
  parameter int          SIZE  = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input logic            CLK,
  input logic            RESET,
  fetch_queue_if.slave   fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Storage; contents are don't-care after reset, so no reset on the arrays
  logic [SIZE-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             has_entry;
  logic             ready;
  logic             push;
  logic             pop;
  logic             bypass_active;
  logic             bypass_consume;

  logic             head_valid;
  logic [SIZE-1:0]  head_pc;
  logic [31:0]      head_instr;

  // Ready depends only on registered occupancy, never on a same-cycle pop
  assign has_entry = (count_q != '0);
  assign ready     = (count_q != FULL_COUNT);

  // Head selection: stored entry at the read pointer, or the live fetch word
  // when the bypass is built in and the queue is empty
  always_comb begin
    head_valid    = has_entry;
    head_pc       = pc_mem[rd_ptr_q];
    head_instr    = instr_mem[rd_ptr_q];
    bypass_active = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!has_entry && fq.ValidF) begin
      bypass_active = 1'b1;
      head_valid    = 1'b1;
      head_pc       = fq.PCF;
      head_instr    = fq.InstrF;
    end
`endif
  end

  // A bypassed word taken by decode in the same cycle never enters storage
  assign bypass_consume = bypass_active & ~fq.StallD & ~fq.FlushD;

  // Handshake qualifiers; a flush cancels both directions
  assign push = fq.ValidF & ready & ~fq.FlushD & ~bypass_consume;
  assign pop  = has_entry & ~fq.StallD & ~fq.FlushD;

  // Decode-facing outputs; invalid head reads as a NOP at PC 0
  always_comb begin
    fq.ValidD   = head_valid;
    fq.InstrD   = NOP;
    fq.PCD      = '0;
    fq.PCPlus4D = '0;
    if (head_valid) begin
      fq.InstrD   = head_instr;
      fq.PCD      = head_pc;
      fq.PCPlus4D = head_pc + SIZE'(4);
    end
  end

  assign fq.ReadyF = ready;
  assign fq.Count  = count_q;

  // Next-state for pointers and occupancy; flush takes precedence over all
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq.FlushD) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: asynchronous active-low reset empties the queue
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: written at the write pointer on every accepted push
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fq.PCF;
      instr_mem[wr_ptr_q] <= fq.InstrF;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue (DEPTH=4).
// Build with +define+FETCH_QUEUE_BYPASS_EN to exercise the bypass variant.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_queue_if #(.SIZE(32), .DEPTH(4)) fq ();

  fetch_queue #(.SIZE(32), .DEPTH(4), .NOP(NOP)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .fq    (fq)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid_f;
    logic [31:0] pc_f;
    logic        stall_d;
    logic        flush_d;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [16];

  // Distinct instruction word tied to each PC so order errors are visible
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {8'hA5, pc[23:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Park inputs: no fetch word, decode holding, no flush
  task automatic driveIdle();
    fq.ValidF = 1'b0;
    fq.PCF    = 32'h0;
    fq.InstrF = 32'h0;
    fq.StallD = 1'b1;
    fq.FlushD = 1'b0;
  endtask

  // Present one cycle of inputs across a rising edge, then park
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic stall, input logic flush);
    @(negedge clk);
    fq.ValidF = v;
    fq.PCF    = pc;
    fq.InstrF = instr_of(pc);
    fq.StallD = stall;
    fq.FlushD = flush;
    @(posedge clk);
    #1;
    driveIdle();
  endtask

  // Full head/occupancy check against an expected registered state
  task automatic checkHead(input string tag, input logic v, input logic [31:0] pc,
                           input logic [2:0] cnt, input logic rdy);
    checkOutput({tag, ".ValidD"},   {31'b0, fq.ValidD}, {31'b0, v});
    checkOutput({tag, ".PCD"},      fq.PCD,      v ? pc : 32'h0);
    checkOutput({tag, ".PCPlus4D"}, fq.PCPlus4D, v ? pc + 32'd4 : 32'h0);
    checkOutput({tag, ".InstrD"},   fq.InstrD,   v ? instr_of(pc) : NOP);
    checkOutput({tag, ".Count"},    {29'b0, fq.Count}, {29'b0, cnt});
    checkOutput({tag, ".ReadyF"},   {31'b0, fq.ReadyF}, {31'b0, rdy});
  endtask

  initial begin
    int sent;
    int recv;
    int cycles;
    checks   = 0;
    failures = 0;
    driveIdle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkHead("reset", 1'b0, 32'h0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // inputs {valid, pc, stall, flush} -> state after the edge {valid, pc, count, ready}
    vecs[0]  = '{1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00, 3'd1, 1'b1};
    vecs[1]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h00, 3'd2, 1'b1};
    vecs[2]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h00, 3'd3, 1'b1};
    vecs[3]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    vecs[4]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h00, 3'd4, 1'b0};
    vecs[5]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h04, 3'd3, 1'b1};
    vecs[6]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h08, 3'd3, 1'b1};
    vecs[7]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h0C, 3'd3, 1'b1};
    vecs[8]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h10, 3'd2, 1'b1};
    vecs[9]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h14, 3'd2, 1'b1};
    vecs[10] = '{1'b1, 32'h1C, 1'b1, 1'b0, 1'b1, 32'h14, 3'd3, 1'b1};
    vecs[11] = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 1'b1};
    vecs[12] = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 32'h24, 3'd1, 1'b1};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1};
    vecs[14] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 3'd1, 1'b1};
    vecs[15] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid_f, vecs[i].pc_f, vecs[i].stall_d, vecs[i].flush_d);
      checkHead($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_count, vecs[i].exp_ready);
    end

    // Asynchronous reset mid-fill with three entries held
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h48, 1'b1, 1'b0);
    checkHead("prereset", 1'b1, 32'h40, 3'd3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkHead("async_reset", 1'b0, 32'h0, 3'd0, 1'b1);
    fq.ValidF = 1'b1;
    fq.PCF    = 32'h4C;
    fq.InstrF = instr_of(32'h4C);
    @(posedge clk);
    #1;
    driveIdle();
    checkHead("reset_hold", 1'b0, 32'h0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with random decode stalls across several pointer wraps
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < 12 && cycles < 1000) begin
      @(negedge clk);
      fq.ValidF = (sent < 12);
      fq.PCF    = 32'h1000 + 32'(sent) * 4;
      fq.InstrF = instr_of(fq.PCF);
      fq.StallD = 1'($urandom_range(0, 1));
      fq.FlushD = 1'b0;
      #1;
      if (fq.ValidF && fq.ReadyF) sent++;
      if (fq.ValidD && !fq.StallD) begin
        checkOutput("stream.PCD", fq.PCD, 32'h1000 + 32'(recv) * 4);
        checkOutput("stream.InstrD", fq.InstrD, instr_of(32'h1000 + 32'(recv) * 4));
        recv++;
      end
      cycles++;
    end
    @(posedge clk);
    #1;
    driveIdle();
    checkOutput("stream.received", 32'(recv), 32'd12);
    checkHead("stream.drained", 1'b0, 32'h0, 3'd0, 1'b1);

    // Empty queue, word arrives while decode is ready
    @(negedge clk);
    fq.ValidF = 1'b1;
    fq.PCF    = 32'h100;
    fq.InstrF = instr_of(32'h100);
    fq.StallD = 1'b0;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checkOutput("bypass.same.ValidD", {31'b0, fq.ValidD}, 32'd1);
    checkOutput("bypass.same.PCD", fq.PCD, 32'h100);
    checkOutput("bypass.same.PCPlus4D", fq.PCPlus4D, 32'h104);
    @(posedge clk);
    #1;
    driveIdle();
    checkHead("bypass.after", 1'b0, 32'h0, 3'd0, 1'b1);
`else
    checkOutput("nobypass.same.ValidD", {31'b0, fq.ValidD}, 32'd0);
    checkOutput("nobypass.same.InstrD", fq.InstrD, NOP);
    @(posedge clk);
    #1;
    driveIdle();
    checkHead("nobypass.after", 1'b1, 32'h100, 3'd1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkHead("nobypass.drain", 1'b0, 32'h0, 3'd0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
